// File: rtl/lcode_pkg.sv
// ---------------------------------------------------------------------------
// lcode_pkg
// Shared definitions for the E1 line-code encoder (lcodenc):
//   - line-code mode constants (AMI / HDB-n)
//   - legal range of the zero-run length parameter
//   - field widths and layout of one tagged window stage
// ---------------------------------------------------------------------------
package lcode_pkg;

    // Line-code mode selected on the mode input
    localparam logic LC_AMI = 1'b0;
    localparam logic LC_HDB = 1'b1;

    // Legal zero-run lengths (4 = HDB3)
    localparam int ZLEN_MIN = 2;
    localparam int ZLEN_MAX = 8;

    // One window stage: NRZ data bit plus the substitution tags
    localparam int DATA_W  = 1;
    localparam int BTAG_W  = 1;
    localparam int VTAG_W  = 1;
    localparam int STAGE_W = DATA_W + BTAG_W + VTAG_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;  // original NRZ bit (1 = mark)
        logic [BTAG_W-1:0] btag;  // zero rewritten as a balancing B pulse
        logic [VTAG_W-1:0] vtag;  // zero rewritten as a violation V pulse
    } stage_t;

endpackage

// File: rtl/lcodenc_if.sv
// ---------------------------------------------------------------------------
// lcodenc_if
// Bit-stream bundle between the framer side (master) and the line-code
// encoder (slave).
//   clken  bit enable, one per tributary bit
//   serin  serial NRZ data
//   mode   0 = AMI, 1 = HDB-n substitution
//   ais    force all-ones
//   opos   positive line pulse (registered)
//   oneg   negative line pulse (registered)
//   osub   strobe for a cycle in which a V pulse was emitted
// ---------------------------------------------------------------------------
interface lcodenc_if;
    logic clken;
    logic serin;
    logic mode;
    logic ais;
    logic opos;
    logic oneg;
    logic osub;

    modport master (output clken, serin, mode, ais, input  opos, oneg, osub);
    modport slave  (input  clken, serin, mode, ais, output opos, oneg, osub);
endinterface

// File: rtl/lcode_dff.sv
// ---------------------------------------------------------------------------
// lcode_dff
// Codebase flop primitive: W-bit register with load enable and
// asynchronous active-low reset to RST_VAL.
//   clk   clock
//   rst   asynchronous reset, active low
//   en    load enable
//   d     next value
//   q     registered value
// ---------------------------------------------------------------------------
module lcode_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others, independent of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lcodwin.sv
// ---------------------------------------------------------------------------
// lcodwin
// ZLEN-deep tagged shift window. Stage 0 takes the newest bit, stage ZLEN-1
// is the one leaving the window this bit period.
//   clk, rst   clock / asynchronous active-low reset
//   en         bit enable; the window shifts only when set
//   din        effective NRZ bit entering stage 0
//   sub        substitution event: incoming zero becomes a V
//   btag_set   with sub, the bit moving into the last stage becomes a B
//   exit_stage contents of the oldest stage (being emitted)
// ---------------------------------------------------------------------------
module lcodwin
    import lcode_pkg::*;
#(
    parameter int ZLEN = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   din,
    input  logic   sub,
    input  logic   btag_set,
    output stage_t exit_stage
);

    stage_t [ZLEN-1:0] win_q;
    stage_t [ZLEN-1:0] win_d;

    always_comb begin
        // NOTE: assign every combinational output a default first so no path
        // leaves it unassigned and a latch is never inferred.
        win_d = win_q;
        win_d[0].data = din;
        win_d[0].btag = 1'b0;
        win_d[0].vtag = sub;
        for (int i = 1; i < ZLEN; i++) begin
            win_d[i] = win_q[i-1];
        end
        // The zero shifting into the last stage is the oldest of the run
        if (sub && btag_set) begin
            win_d[ZLEN-1].btag = 1'b1;
        end
    end

    // NOTE: the window is reset, not left as uninitialised storage, because
    // stale tags would otherwise leak out as pulses after reset.
    lcode_dff #(.W(ZLEN*STAGE_W)) u_win (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (win_d),
        .q   (win_q)
    );

    assign exit_stage = win_q[ZLEN-1];

endmodule

// File: rtl/lcodenc.sv
// ---------------------------------------------------------------------------
// lcodenc
// E1 line-code encoder: serial NRZ -> dual-rail pos/neg pulses, plain AMI or
// HDB-n zero substitution (ZLEN zeros, HDB3 by default), with per-bit clock
// enable and AIS all-ones forcing. Latency is ZLEN enabled bits.
//   clk   system clock
//   rst   asynchronous reset, active low
//   bus   lcodenc_if.slave (clken, serin, mode, ais -> opos, oneg, osub)
// ---------------------------------------------------------------------------
module lcodenc
    import lcode_pkg::*;
#(
    parameter int ZLEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    lcodenc_if.slave   bus
);

    if (ZLEN < ZLEN_MIN || ZLEN > ZLEN_MAX) begin : g_zlen_check
        $error("lcodenc: ZLEN=%0d outside %0d..%0d", ZLEN, ZLEN_MIN, ZLEN_MAX);
    end

    localparam int              ZC_W   = $clog2(ZLEN);
    localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(ZLEN - 1);

    logic            d;
    logic            sub;
    logic            btag_set;
    logic            is_b;
    logic            is_v;
    stage_t          exit_stage;
    logic [ZC_W-1:0] zc_q, zc_d;
    logic            lastpol_q, lastpol_d;   // 1 = last pulse was negative
    logic            parity_q, parity_d;     // B pulses since last V, mod 2
    logic            opos_d, oneg_d, osub_d;
    logic            opos_q, oneg_q, osub_q;

    assign d    = bus.serin | bus.ais;
    assign is_b = exit_stage.data[0] | exit_stage.btag[0];
    assign is_v = exit_stage.vtag[0];

    always_comb begin
        zc_d = zc_q;
        sub  = 1'b0;
        if (d) begin
            zc_d = '0;
        end else if (zc_q != ZC_MAX) begin
            zc_d = zc_q + 1'b1;
        end else if (bus.mode == LC_HDB) begin
            sub  = 1'b1;
            zc_d = '0;
        end

        // Polarity state after emitting the exiting stage
        parity_d  = parity_q;
        lastpol_d = lastpol_q;
        if (is_b) begin
            parity_d  = ~parity_q;
            lastpol_d = ~lastpol_q;
        end else if (is_v) begin
            parity_d  = 1'b0;
        end

        // Substitution needs the parity seen once this edge's pulse is out
        btag_set = ~parity_d;

        // B alternates against the last pulse; V repeats it
        opos_d = (is_b & lastpol_q) | (is_v & ~lastpol_q);
        oneg_d = (is_b & ~lastpol_q) | (is_v & lastpol_q);
        osub_d = bus.clken & is_v;
    end

    lcodwin #(.ZLEN(ZLEN)) u_win (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.clken),
        .din        (d),
        .sub        (sub),
        .btag_set   (btag_set),
        .exit_stage (exit_stage)
    );

    lcode_dff #(.W(ZC_W)) u_zc (
        .clk (clk), .rst (rst), .en (bus.clken), .d (zc_d), .q (zc_q)
    );

    // First pulse after reset must be positive, so lastpol resets to 1
    lcode_dff #(.W(1), .RST_VAL(1'b1)) u_lastpol (
        .clk (clk), .rst (rst), .en (bus.clken), .d (lastpol_d), .q (lastpol_q)
    );

    lcode_dff #(.W(1)) u_parity (
        .clk (clk), .rst (rst), .en (bus.clken), .d (parity_d), .q (parity_q)
    );

    // Pulses hold over clken gaps to give full-bit-width NRZ pulses
    lcode_dff #(.W(2)) u_out (
        .clk (clk), .rst (rst), .en (bus.clken),
        .d   ({opos_d, oneg_d}), .q ({opos_q, oneg_q})
    );

    // Strobe reloads every cycle so it drops on cycles without an enable
    lcode_dff #(.W(1)) u_osub (
        .clk (clk), .rst (rst), .en (1'b1), .d (osub_d), .q (osub_q)
    );

    assign bus.opos = opos_q;
    assign bus.oneg = oneg_q;
    assign bus.osub = osub_q;

endmodule

// File: tb/tb_lcodenc.sv
// ---------------------------------------------------------------------------
// tb_lcodenc
// Self-checking bench for lcodenc (ZLEN=4). A symbol-level HDB-n/AMI model
// turns each entered bit into 0/1/B/V symbols, assigns alternate-mark
// polarity, and queues the expected pulse for every enable. A monitor pops
// and compares after each enabled edge and checks hold behaviour in gaps.
// Directed sequences are also compared against hand-written pulse strings.
// ---------------------------------------------------------------------------
module tb_lcodenc;
    import lcode_pkg::*;

    localparam int ZLEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lcodenc_if bus ();

    lcodenc #(.ZLEN(ZLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef enum {S_ZERO, S_ONE, S_B, S_V} sym_e;
    typedef struct {
        logic pos;
        logic neg;
        logic sub;
    } exp_t;

    sym_e sym[$];      // one symbol per bit entered since reset
    int   run_len;     // zeros since the last mark or substitution
    int   mpol;        // polarity of the last emitted pulse, +1 / -1
    exp_t exp_q[$];

    function automatic void model_reset();
        sym.delete();
        run_len = 0;
        mpol    = -1;
    endfunction

    // Enter one bit; queue the pulse expected on this same enable edge
    function automatic void model_bit(input logic din, input logic m);
        int   i;
        int   par;
        exp_t e;
        i = sym.size();
        if (din) begin
            sym.push_back(S_ONE);
            run_len = 0;
        end else if (m == LC_HDB && run_len >= ZLEN - 1) begin
            par = 0;
            for (int j = i - 1; j >= 0 && sym[j] != S_V; j--) begin
                if (sym[j] == S_ONE || sym[j] == S_B) par ^= 1;
            end
            if (par == 0) sym[i-ZLEN+1] = S_B;
            sym.push_back(S_V);
            run_len = 0;
        end else begin
            sym.push_back(S_ZERO);
            run_len++;
        end

        e = '{pos: 1'b0, neg: 1'b0, sub: 1'b0};
        if (i >= ZLEN) begin
            case (sym[i-ZLEN])
                S_ONE, S_B: begin
                    mpol  = -mpol;
                    e.pos = (mpol > 0);
                    e.neg = (mpol < 0);
                end
                S_V: begin
                    e.pos = (mpol > 0);
                    e.neg = (mpol < 0);
                    e.sub = 1'b1;
                end
                default: ;
            endcase
        end
        exp_q.push_back(e);
    endfunction

    // ---------------------------------------------------------------- monitor
    bit   mon_on = 1'b0;
    bit   was_en;
    bit   was_rst;
    exp_t last_exp = '{pos: 1'b0, neg: 1'b0, sub: 1'b0};
    byte  cap[$];      // observed pulse per enable: + - 0 P(V+) N(V-)

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            was_en  = bus.clken;
            was_rst = rst;
            @(negedge clk);
            if (mon_on && rst && was_rst) begin
                check("excl", {31'd0, bus.opos & bus.oneg}, 32'd0);
                if (was_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL underrun: output with no expected entry at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("opos", {31'd0, bus.opos}, {31'd0, e.pos});
                        check("oneg", {31'd0, bus.oneg}, {31'd0, e.neg});
                        check("osub", {31'd0, bus.osub}, {31'd0, e.sub});
                        last_exp = e;
                    end
                    if (bus.osub) cap.push_back(bus.opos ? "P" : "N");
                    else if (bus.opos) cap.push_back("+");
                    else if (bus.oneg) cap.push_back("-");
                    else cap.push_back("0");
                end else begin
                    check("hold_opos", {31'd0, bus.opos}, {31'd0, last_exp.pos});
                    check("hold_oneg", {31'd0, bus.oneg}, {31'd0, last_exp.neg});
                    check("gap_osub", {31'd0, bus.osub}, 32'd0);
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic send(input logic s, input logic a, input logic m, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bus.clken = 1'b0;
            bus.serin = 1'($urandom);
            bus.ais   = 1'($urandom);
            bus.mode  = 1'($urandom);
        end
        @(negedge clk);
        bus.clken = 1'b1;
        bus.serin = s;
        bus.ais   = a;
        bus.mode  = m;
        model_bit(s | a, m);
    endtask

    task automatic flush_ones(input logic m);
        for (int k = 0; k < ZLEN; k++) send(1'b1, 1'b0, m, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.clken = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        bus.clken = 1'b0;
        #2;
        mon_on = 1'b0;
        rst    = 1'b0;
        #1;
        if (chk) begin
            check("rst_opos", {31'd0, bus.opos}, 32'd0);
            check("rst_oneg", {31'd0, bus.oneg}, 32'd0);
            check("rst_osub", {31'd0, bus.osub}, 32'd0);
        end
        model_reset();
        exp_q.delete();
        cap.delete();
        last_exp = '{pos: 1'b0, neg: 1'b0, sub: 1'b0};
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic check_seq(input string name, input string want);
        check({name, "_len"}, cap.size(), want.len());
        for (int k = 0; k < want.len() && k < cap.size(); k++) begin
            check(name, {24'd0, cap[k]}, {24'd0, want[k]});
        end
    endtask

    task automatic send_bits(input string bits, input logic m);
        for (int k = 0; k < bits.len(); k++) send(bits[k] == "1", 1'b0, m, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic m;
        bus.clken = 1'b0;
        bus.serin = 1'b0;
        bus.ais   = 1'b0;
        bus.mode  = 1'b0;
        model_reset();

        // Reset state
        do_reset(1'b1);

        // Plain AMI, long zero run untouched
        send_bits("110100001", LC_AMI);
        flush_ones(LC_AMI);
        idle();
        check_seq("ami", "0000+-0+0000-");

        // 000V, then B00V, then a mark
        do_reset(1'b0);
        send_bits("1000000001", LC_HDB);
        flush_ones(LC_HDB);
        idle();
        check_seq("hdb_v_bv", "0000+000P-00N+");

        // Eight zeros from reset: two B00V
        do_reset(1'b0);
        send_bits("00000000", LC_HDB);
        flush_ones(LC_HDB);
        idle();
        check_seq("hdb_2x", "0000+00P-00N");

        // Seven zeros then a mark
        do_reset(1'b0);
        send_bits("00000001", LC_HDB);
        flush_ones(LC_HDB);
        idle();
        check_seq("hdb_7z", "0000+00P000-");

        // AIS forces marks regardless of serin
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) send(1'($urandom), 1'b1, LC_HDB, 0);
        flush_ones(LC_HDB);
        idle();
        check_seq("ais", "0000+-+-+-");

        // Reset during a run of three zeros
        do_reset(1'b0);
        send_bits("1111000", LC_HDB);
        idle();
        check_seq("pre_rst", "0000+-+");
        do_reset(1'b1);
        send_bits("0000", LC_HDB);
        flush_ones(LC_HDB);
        idle();
        check_seq("post_rst", "0000+00P");

        // Random data, modes and enable gaps against the model
        do_reset(1'b0);
        m = LC_HDB;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            send(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), m,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end
        idle();
        check("drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
